// File: rtl/key_unlock_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_unlock_ctrl_if
//  Description : Serial key-provisioning handshake (valid/data/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_unlock_ctrl_if;
    logic kin_valid;
    logic kin_data;
    logic kin_ready;

    // master = key provisioner, slave = unlock controller
    modport master (output kin_valid, output kin_data, input kin_ready);
    modport slave  (input kin_valid, input kin_data, output kin_ready);
endinterface
`default_nettype wire

// File: rtl/key_unlock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_unlock_ctrl
//  Description : Loads a serial unlock key, applies it to a logic-locked full
//                adder and self-tests the core over all 8 input vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_unlock_ctrl #(
    parameter int KEY_W = 2,
    parameter int CNT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    key_unlock_ctrl_if.slave      kin,
    output logic [KEY_W-1:0]      key,
    output logic                  test_mode,
    output logic                  chk_a,
    output logic                  chk_b,
    output logic                  chk_cin,
    input  wire logic             chk_q,
    input  wire logic             chk_cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_CHECK = 3'd2,
        S_READY = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    localparam logic [2:0]       c_last_vec = 3'd7;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(KEY_W - 1);

    state_t           r_state;
    logic [KEY_W-1:0] r_sreg;
    logic [KEY_W-1:0] r_key;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_vec;
    logic             r_ph;
    logic             r_kin_ready;
    logic             r_test_mode;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic [KEY_W-1:0] w_sreg_next;
    logic             w_exp_q;
    logic             w_exp_cout;
    logic             w_vec_ok;

    assign w_accept    = kin.kin_valid & r_kin_ready;
    // LSB-first: each new bit enters at the top and earlier bits move down
    assign w_sreg_next = KEY_W'({kin.kin_data, r_sreg} >> 1);

    // Golden full-adder response for the vector currently on chk_*
    assign w_exp_q    = r_vec[2] ^ r_vec[1] ^ r_vec[0];
    assign w_exp_cout = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
    assign w_vec_ok   = (chk_q == w_exp_q) && (chk_cout == w_exp_cout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_key       <= '0;
            r_cnt       <= '0;
            r_vec       <= '0;
            r_ph        <= 1'b0;
            r_kin_ready <= 1'b0;
            r_test_mode <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_READY, S_FAIL: begin
                    // key keeps its old value until the new one is fully shifted in
                    if (start) begin
                        r_state     <= S_SHIFT;
                        r_sreg      <= '0;
                        r_cnt       <= '0;
                        r_kin_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    if (w_accept) begin
                        r_sreg <= w_sreg_next;
                        if (r_cnt == c_last_bit) begin
                            r_key       <= w_sreg_next;
                            r_state     <= S_CHECK;
                            r_vec       <= '0;
                            r_ph        <= 1'b0;
                            r_kin_ready <= 1'b0;
                            r_test_mode <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                S_CHECK: begin
                    if (!r_ph) begin
                        r_ph <= 1'b1;
                    end else if (!w_vec_ok) begin
                        // wrong key: drop it so the core stays locked
                        r_state     <= S_FAIL;
                        r_key       <= '0;
                        r_vec       <= '0;
                        r_ph        <= 1'b0;
                        r_test_mode <= 1'b0;
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                    end else if (r_vec == c_last_vec) begin
                        r_state     <= S_READY;
                        r_vec       <= '0;
                        r_ph        <= 1'b0;
                        r_test_mode <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_vec <= r_vec + 3'd1;
                        r_ph  <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_kin_ready <= 1'b0;
                    r_test_mode <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                end
            endcase
        end
    end

    // r_vec is held at zero outside CHECK, so chk_* idle low
    assign kin.kin_ready = r_kin_ready;
    assign key           = r_key;
    assign test_mode     = r_test_mode;
    assign chk_a         = r_vec[2];
    assign chk_b         = r_vec[1];
    assign chk_cin       = r_vec[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_key_unlock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_unlock_ctrl
//  Description : Directed and randomized bench for key_unlock_ctrl driving a
//                locked full-adder core model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_unlock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] key;
    logic       test_mode, chk_a, chk_b, chk_cin, chk_q, chk_cout;
    logic       busy, done, err;
    int         vectors = 0;
    int         miscompares = 0;

    key_unlock_ctrl_if kin_if ();

    key_unlock_ctrl #(.KEY_W(2), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .kin       (kin_if),
        .key       (key),
        .test_mode (test_mode),
        .chk_a     (chk_a),
        .chk_b     (chk_b),
        .chk_cin   (chk_cin),
        .chk_q     (chk_q),
        .chk_cout  (chk_cout),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Locked adder: Q is inverted unless some key bit is set, COUT is
    // corrupted by key_1 whenever B and CIN are both high. Only key 2'b01 unlocks.
    assign chk_q    = chk_a ^ chk_b ^ chk_cin ^ ~(key[0] | key[1]);
    assign chk_cout = ((chk_a & chk_b) | (chk_a & chk_cin) | (chk_b & chk_cin))
                      ^ (key[1] & chk_b & chk_cin);

    // Reference: first vector whose locked-core response differs from a true
    // full adder (8 = none), computed with plain arithmetic.
    function automatic int first_bad(input logic [1:0] k);
        for (int v = 0; v < 8; v++) begin
            int a = (v >> 2) & 1;
            int b = (v >> 1) & 1;
            int c = v & 1;
            int s = a + b + c;
            int want_q = s % 2;
            int want_c = (s >= 2) ? 1 : 0;
            int got_q  = want_q ^ ((k == 2'b00) ? 1 : 0);
            int got_c  = want_c ^ ((k[1] && b == 1 && c == 1) ? 1 : 0);
            if (got_q != want_q || got_c != want_c) return v;
        end
        return 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start, then KEY_W bits LSB first with 'gap' idle cycles before each;
    // 'junk' raises kin_valid together with start (must not be counted)
    task automatic load_key(input logic [1:0] k, input int gap, input bit junk);
        start = 1'b1;
        if (junk) begin
            kin_if.kin_valid = 1'b1;
            kin_if.kin_data  = ~k[0];
        end
        tick();
        start = 1'b0;
        kin_if.kin_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            repeat (gap) tick();
            kin_if.kin_valid = 1'b1;
            kin_if.kin_data  = k[i];
            tick();
            kin_if.kin_valid = 1'b0;
        end
    endtask

    task automatic count_check(output int n);
        n = 0;
        while (test_mode === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_key"}, 32'(key), 32'd0);
        check({tag, "_outs"}, {26'd0, kin_if.kin_ready, busy, done, err, test_mode, chk_a},
              32'd0);
    endtask

    initial begin
        int n;
        int fb;
        logic [1:0] k;
        int gap;
        bit junk;

        kin_if.kin_valid = 1'b0;
        kin_if.kin_data  = 1'b0;

        // reset
        repeat (2) tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        check_idle("idle_hold");

        // good key: bits 1,0
        load_key(2'b01, 0, 1'b0);
        check("good_key_loaded", 32'(key), 32'd1);
        check("good_test_mode", 32'(test_mode), 32'd1);
        count_check(n);
        check("good_check_cycles", 32'(n), 32'd16);
        check("good_done_err", {30'd0, done, err}, 32'b10);
        check("good_key_held", 32'(key), 32'd1);

        // wrong key 00 from READY: done drops next cycle, old key held during SHIFT
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rekey_done_drop", {29'd0, done, busy, kin_if.kin_ready}, 32'b011);
        check("rekey_key_held", 32'(key), 32'd1);
        for (int i = 0; i < 2; i++) begin
            kin_if.kin_valid = 1'b1;
            kin_if.kin_data  = 1'b0;
            tick();
        end
        kin_if.kin_valid = 1'b0;
        count_check(n);
        check("bad00_check_cycles", 32'(n), 32'd2);
        check("bad00_err_done", {30'd0, err, done}, 32'b10);
        check("bad00_key_zero", 32'(key), 32'd0);

        // valid pulses in IDLE, junk at start, gapped bits
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kin_if.kin_valid = i[0];
            kin_if.kin_data  = 1'b1;
            tick();
        end
        kin_if.kin_valid = 1'b0;
        check_idle("idle_pulses");
        load_key(2'b01, 2, 1'b1);
        check("gap_key", 32'(key), 32'd1);
        count_check(n);
        check("gap_done", {30'd0, done, err}, 32'b10);

        // reset in CHECK at vector 4
        load_key(2'b01, 0, 1'b0);
        repeat (8) tick();
        check("v4_drive", {29'd0, chk_a, chk_b, chk_cin}, 32'b100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("rst_in_check");
        repeat (3) tick();
        check_idle("rst_stays_idle");

        // re-key 10 fails at vector 3, then 01 recovers
        load_key(2'b01, 0, 1'b0);
        count_check(n);
        check("pre_rekey_done", 32'(done), 32'd1);
        load_key(2'b10, 0, 1'b0);
        check("k10_loaded", 32'(key), 32'd2);
        count_check(n);
        check("k10_check_cycles", 32'(n), 32'd8);
        check("k10_err", {30'd0, err, done}, 32'b10);
        check("k10_key_zero", 32'(key), 32'd0);
        load_key(2'b01, 1, 1'b0);
        count_check(n);
        check("recover_cycles", 32'(n), 32'd16);
        check("recover_done", {30'd0, done, err}, 32'b10);

        // randomized keys and handshake gaps
        for (int it = 0; it < 24; it++) begin
            k    = 2'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 3));
            junk = 1'($urandom_range(0, 1));
            fb   = first_bad(k);
            load_key(k, gap, junk);
            check("rnd_key_loaded", 32'(key), 32'(k));
            count_check(n);
            check("rnd_check_cycles", 32'(n), (fb == 8) ? 32'd16 : 32'(2 * fb + 2));
            check("rnd_done_err", {30'd0, done, err}, (fb == 8) ? 32'b10 : 32'b01);
            check("rnd_final_key", 32'(key), (fb == 8) ? 32'(k) : 32'd0);
            check("rnd_busy", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
